endstop_abort_ctrl: RTL and testbench

//  Monitors the eight endstop inputs and turns filtered hits into per-axis abort strobes for the

---
 rtl/endstop_pkg.sv | 13 +
 rtl/endstop_debounce.sv | 40 ++++
 rtl/endstop_abort_ctrl.sv | 95 +++++++++
 tb/tb_endstop_abort_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/endstop_pkg.sv
// Shared types and defaults for the endstop abort controller.
package endstop_pkg;

  localparam int CHANNELS_DEF = 8;
  localparam int DEB_W_DEF    = 16;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_TRIPPED  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/endstop_debounce.sv
// One endstop channel: 2-FF synchroniser, polarity correction and stability filter.
module endstop_debounce
  import endstop_pkg::*;
#(
  parameter int DEB_W = DEB_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw,
  input  logic             polarity,
  input  logic [DEB_W-1:0] debounce,
  output logic             filtered
);

  logic [1:0]       sync_q;
  logic             hit_sync;
  logic [DEB_W-1:0] cnt_q;

  assign hit_sync = sync_q[1] ^ polarity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      filtered <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      // cnt_q counts prior mismatching cycles, so D=0 accepts after one stable cycle
      if (hit_sync == filtered) begin
        cnt_q <= '0;
      end else if (cnt_q >= debounce) begin
        filtered <= hit_sync;
        cnt_q    <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/endstop_abort_ctrl.sv
// Per-axis endstop arming FSMs; converts filtered hits into single-cycle abort/interrupt pulses.
module endstop_abort_ctrl
  import endstop_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int DEB_W    = DEB_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] endstop_raw,
  input  logic [CHANNELS-1:0] cfg_polarity,
  input  logic [CHANNELS-1:0] cfg_enable,
  input  logic [DEB_W-1:0]    cfg_debounce,
  input  logic                arm,
  input  logic                disarm,
  input  logic [CHANNELS-1:0] clear_hits,
  output logic [CHANNELS-1:0] abort,
  output logic [CHANNELS-1:0] hit_int,
  output logic [CHANNELS-1:0] status,
  output logic [CHANNELS-1:0] hit_latched,
  output logic [CHANNELS-1:0] armed
);

  logic [CHANNELS-1:0] filtered;
  logic [CHANNELS-1:0] trip;
  logic [CHANNELS-1:0] abort_q;
  logic [CHANNELS-1:0] hit_q;
  ch_state_e           st_q [CHANNELS];
  ch_state_e           st_d [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    endstop_debounce #(.DEB_W(DEB_W)) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (endstop_raw[g]),
      .polarity (cfg_polarity[g]),
      .debounce (cfg_debounce),
      .filtered (filtered[g])
    );
    assign armed[g] = (st_q[g] == ST_ARMED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) st_q[i] <= ST_DISARMED;
    end else begin
      for (int i = 0; i < CHANNELS; i++) st_q[i] <= st_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      st_d[i] = st_q[i];
      trip[i] = 1'b0;
      if (disarm) begin
        st_d[i] = ST_DISARMED;
      end else begin
        unique case (st_q[i])
          ST_DISARMED: if (arm && cfg_enable[i]) begin
            // arming onto an already-hit stop trips at once so the axis cannot drive into it
            st_d[i] = filtered[i] ? ST_TRIPPED : ST_ARMED;
            trip[i] = filtered[i];
          end
          ST_ARMED: begin
            if (filtered[i]) begin
              st_d[i] = ST_TRIPPED;
              trip[i] = 1'b1;
            end else if (!cfg_enable[i]) begin
              st_d[i] = ST_DISARMED;
            end
          end
          ST_TRIPPED: if (clear_hits[i]) st_d[i] = ST_DISARMED;
          default: st_d[i] = ST_DISARMED;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_q <= '0;
      hit_q   <= '0;
    end else begin
      abort_q <= trip;
      // a trip in the same cycle as a clear keeps the flag set
      hit_q   <= trip | (hit_q & ~clear_hits);
    end
  end

  assign abort       = abort_q;
  assign hit_int     = abort_q;
  assign status      = filtered;
  assign hit_latched = hit_q;

endmodule

// File: tb/tb_endstop_abort_ctrl.sv
// Bench for endstop_abort_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_endstop_abort_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  endstop_raw = '0, cfg_polarity = '0, cfg_enable = '0, clear_hits = '0;
  logic [15:0] cfg_debounce = 16'd3;
  logic        arm = 1'b0, disarm = 1'b0;
  logic [7:0]  abort, hit_int, status, hit_latched, armed;

  int errors = 0;
  int checks = 0;

  endstop_abort_ctrl dut (
    .clk(clk), .rst_n(rst_n), .endstop_raw(endstop_raw), .cfg_polarity(cfg_polarity),
    .cfg_enable(cfg_enable), .cfg_debounce(cfg_debounce), .arm(arm), .disarm(disarm),
    .clear_hits(clear_hits), .abort(abort), .hit_int(hit_int), .status(status),
    .hit_latched(hit_latched), .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pins seen two cycles late; a channel's filtered level flips once the corrected
  // pin has disagreed with it for D+1 consecutive cycles. Per channel the model tracks
  // "armed" and "tripped" flags; a trip emits a one-cycle pulse and sets the sticky flag.
  logic [7:0] m_s1 = '0, m_s2 = '0, m_filt = '0, m_arm = '0, m_trip = '0, m_hl = '0, m_pulse = '0;
  int         m_run [8];

  initial for (int c = 0; c < 8; c++) m_run[c] = 0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] hs, nf, na, nt, nh, np;
    int nr [8];
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_filt <= '0; m_arm <= '0; m_trip <= '0; m_hl <= '0; m_pulse <= '0;
      for (int c = 0; c < 8; c++) m_run[c] <= 0;
    end else begin
      hs = m_s2 ^ cfg_polarity;
      nf = m_filt; na = m_arm; nt = m_trip; nh = m_hl; np = '0;
      for (int c = 0; c < 8; c++) begin
        if (disarm) begin
          na[c] = 1'b0; nt[c] = 1'b0;
        end else if (m_arm[c]) begin
          if (m_filt[c]) begin na[c] = 1'b0; nt[c] = 1'b1; np[c] = 1'b1; end
          else if (!cfg_enable[c]) na[c] = 1'b0;
        end else if (m_trip[c]) begin
          if (clear_hits[c]) nt[c] = 1'b0;
        end else if (arm && cfg_enable[c]) begin
          if (m_filt[c]) begin nt[c] = 1'b1; np[c] = 1'b1; end
          else na[c] = 1'b1;
        end
        if (np[c]) nh[c] = 1'b1;
        else if (clear_hits[c]) nh[c] = 1'b0;
        nr[c] = (hs[c] != m_filt[c]) ? m_run[c] + 1 : 0;
        if (nr[c] > int'(cfg_debounce)) begin nf[c] = hs[c]; nr[c] = 0; end
        m_run[c] <= nr[c];
      end
      m_s1 <= endstop_raw; m_s2 <= m_s1;
      m_filt <= nf; m_arm <= na; m_trip <= nt; m_hl <= nh; m_pulse <= np;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_abort", abort, m_pulse);
      chk("model_hit_int", hit_int, m_pulse);
      chk("model_status", status, m_filt);
      chk("model_hit_latched", hit_latched, m_hl);
      chk("model_armed", armed, m_arm);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1; cyc(1); arm = 1'b0;
  endtask

  task automatic quiesce();
    disarm = 1'b1; clear_hits = 8'hFF; cyc(1); disarm = 1'b0; clear_hits = '0;
  endtask

  initial begin
    int got;
    cyc(3);
    chk("reset_abort", abort, 0);
    chk("reset_status", status, 0);
    chk("reset_hl_armed", {hit_latched, armed}, 0);
    rst_n = 1'b1;

    // 1: basic trip latency D+4
    cfg_debounce = 16'd3; cfg_polarity = '0; cfg_enable = 8'h01;
    cyc(4);
    pulse_arm();
    chk("t1_armed", armed, 8'h01);
    endstop_raw = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      chk("t1_abort_edge", abort, (k == 7) ? 8'h01 : 8'h00);
      chk("t1_hit_int_edge", hit_int, (k == 7) ? 8'h01 : 8'h00);
    end
    chk("t1_hit_latched", hit_latched, 8'h01);
    chk("t1_armed_after", armed, 8'h00);

    // 2: short glitch is rejected
    endstop_raw = '0; cyc(8);
    quiesce(); pulse_arm();
    endstop_raw = 8'h01; cyc(3); endstop_raw = '0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("t2_status", status[0], 1'b0);
      chk("t2_abort", abort, 0);
    end

    // 3: two channels of opposite polarity trip together
    quiesce();
    cfg_enable = 8'hFF; cfg_polarity = 8'h0F; endstop_raw = 8'h0F;
    cyc(10);
    pulse_arm(); cyc(2);
    endstop_raw = 8'h2B;
    got = 0;
    for (int k = 0; k < 15 && got == 0; k++) begin
      cyc(1);
      if (abort != 0) got = 1;
    end
    chk("t3_abort_pair", abort, 8'h24);
    cyc(1);
    chk("t3_single_pulse", abort, 0);

    // 4: arming onto an already-hit stop trips at once
    quiesce();
    endstop_raw = 8'h0D; cyc(10);
    chk("t4_status", status, 8'h02);
    pulse_arm();
    chk("t4_abort", abort, 8'h02);
    chk("t4_armed", armed, 8'hFD);

    // 5: clear coincident with trip loses; later clear wins
    quiesce();
    cfg_polarity = '0; cfg_enable = 8'h01; endstop_raw = '0; cyc(10);
    pulse_arm();
    endstop_raw = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      if (k == 6) clear_hits = 8'h01;
    end
    clear_hits = '0;
    chk("t5_trip_abort", abort, 8'h01);
    chk("t5_hl_kept", hit_latched[0], 1'b1);
    clear_hits = 8'h01; cyc(1); clear_hits = '0;
    chk("t5_hl_cleared", hit_latched[0], 1'b0);
    chk("t5_disarmed", armed, 0);

    // 6: disarm beats arm; async reset while armed
    endstop_raw = '0; cfg_enable = 8'hFF; cyc(8);
    arm = 1'b1; disarm = 1'b1; cyc(1); arm = 1'b0; disarm = 1'b0;
    chk("t6_disarm_wins", armed, 0);
    pulse_arm();
    chk("t6_armed_all", armed, 8'hFF);
    endstop_raw = 8'hFF; cyc(4);
    #3 rst_n = 1'b0;
    #1 chk("t6_reset_outs", {abort, hit_int, status, hit_latched, armed}, 0);
    cyc(2);
    chk("t6_reset_held", {abort, status, armed}, 0);
    endstop_raw = '0; rst_n = 1'b1;
    cyc(3);
    chk("t6_no_pulse", abort, 0);

    // randomized traffic, checked every cycle by the model comparator
    cfg_debounce = 16'd2;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(7) == 0) endstop_raw[$urandom_range(7)] ^= 1'b1;
      arm        = ($urandom_range(15) == 0);
      disarm     = ($urandom_range(59) == 0);
      clear_hits = ($urandom_range(15) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(99) == 0) cfg_enable = 8'($urandom);
      if ($urandom_range(199) == 0) cfg_polarity = 8'($urandom);
      if ($urandom_range(99) == 0) cfg_debounce = 16'($urandom_range(5));
      cyc(1);
    end
    arm = 1'b0; disarm = 1'b0; clear_hits = '0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
